// File: rtl/corr_pkg.sv
// Shared types and defaults for the coincidence integrator.
package corr_pkg;

  localparam int RESOLUTION_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INTEGRATE = 2'd1,
    ST_RESTART   = 2'd2
  } state_e;

endpackage

// File: rtl/sat_accum.sv
// Saturating up-counter with synchronous clear. The 'sum' port shows the
// value this cycle's increment produces, so the owner can capture a window
// total that already includes the final sample.
module sat_accum
  import corr_pkg::*;
#(
  parameter int W = RESOLUTION_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] sum
);

  logic [W-1:0] count_q, count_d;

  // Increment unless already all-ones; clear wins over the increment
  always_comb begin
    sum     = count_q;
    if (inc && (count_q != '1)) sum = count_q + W'(1);
    count_d = clr ? '0 : sum;
  end

  // Count register, zeroed by the active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/corr_integrator.sv
// Coincidence / singles integrator over windows framed by an external
// window counter. Define CORR_INTEGRATOR_SINGLES_EN to build the per-channel
// singles counters; otherwise result_a/result_b read as zero.
module corr_integrator
  import corr_pkg::*;
#(
  parameter int RESOLUTION = RESOLUTION_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sample_a,
  input  logic                  sample_b,
  input  logic                  overflow,
  output logic                  counter_reset,
  output logic [RESOLUTION-1:0] result_cross,
  output logic [RESOLUTION-1:0] result_a,
  output logic [RESOLUTION-1:0] result_b,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  overrun
);

  state_e state_q, state_d;
  logic   overflow_d_q;
  logic   in_int, win_end, acc_clr, load;
  logic   valid_q, valid_d, overrun_q, overrun_d;
  logic [RESOLUTION-1:0] sum_cross, cross_q, cross_d;

  assign in_int  = (state_q == ST_INTEGRATE);
  // Only the rising edge of the level flag ends a window; enable low aborts
  assign win_end = in_int && enable && overflow && !overflow_d_q;
  // Accumulators sit at zero outside INTEGRATE and restart after each window
  assign acc_clr = !in_int || !enable || win_end;

  // Next-state: enable low forces IDLE from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable)    state_d = ST_RESTART;
      ST_INTEGRATE: if (win_end)   state_d = ST_RESTART;
      ST_RESTART:   if (!overflow) state_d = ST_INTEGRATE;
      default:                     state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  // Result handshake: load a finished window unless an unconsumed one blocks it
  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    if (win_end) begin
      if (!valid_q || result_ready) begin
        load    = 1'b1;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && result_ready) begin
      valid_d = 1'b0;
    end
    cross_d = load ? sum_cross : cross_q;
  end

  // State, edge-detect and result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      overflow_d_q <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      cross_q      <= '0;
    end else begin
      state_q      <= state_d;
      overflow_d_q <= overflow;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      cross_q      <= cross_d;
    end
  end

  sat_accum #(.W(RESOLUTION)) u_acc_cross (
    .clk(clk), .reset(reset), .clr(acc_clr),
    .inc(in_int && sample_a && sample_b), .sum(sum_cross)
  );

`ifdef CORR_INTEGRATOR_SINGLES_EN
  logic [RESOLUTION-1:0] sum_a, sum_b, res_a_q, res_a_d, res_b_q, res_b_d;

  sat_accum #(.W(RESOLUTION)) u_acc_a (
    .clk(clk), .reset(reset), .clr(acc_clr),
    .inc(in_int && sample_a), .sum(sum_a)
  );
  sat_accum #(.W(RESOLUTION)) u_acc_b (
    .clk(clk), .reset(reset), .clr(acc_clr),
    .inc(in_int && sample_b), .sum(sum_b)
  );

  // Singles results follow the same load decision as the cross result
  always_comb begin
    res_a_d = load ? sum_a : res_a_q;
    res_b_d = load ? sum_b : res_b_q;
  end

  // Singles result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      res_a_q <= '0;
      res_b_q <= '0;
    end else begin
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
    end
  end

  assign result_a = res_a_q;
  assign result_b = res_b_q;
`else
  assign result_a = '0;
  assign result_b = '0;
`endif

  assign counter_reset = !in_int;
  assign result_cross  = cross_q;
  assign result_valid  = valid_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_corr_integrator.sv
module tb_corr_integrator;

`ifdef CORR_INTEGRATOR_SINGLES_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, enable, sample_a, sample_b, overflow, result_ready;
  logic        crst, rvalid, ovr;
  logic [63:0] rc, ra, rb;
  logic        crst4, rvalid4, ovr4;
  logic [3:0]  rc4, ra4, rb4;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  corr_integrator #(.RESOLUTION(64)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_a(sample_a),
    .sample_b(sample_b), .overflow(overflow), .counter_reset(crst),
    .result_cross(rc), .result_a(ra), .result_b(rb), .result_valid(rvalid),
    .result_ready(result_ready), .overrun(ovr)
  );

  corr_integrator #(.RESOLUTION(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .sample_a(sample_a),
    .sample_b(sample_b), .overflow(overflow), .counter_reset(crst4),
    .result_cross(rc4), .result_a(ra4), .result_b(rb4), .result_valid(rvalid4),
    .result_ready(result_ready), .overrun(ovr4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ov, input logic a, input logic b);
    overflow = ov;
    sample_a = a;
    sample_b = b;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; result_ready = 1'b1;
    drive(0, 0, 0);
    tick(); tick();
    reset = 1'b1;
  endtask

  // IDLE -> RESTART -> INTEGRATE
  task automatic start();
    enable = 1'b1;
    drive(0, 0, 0);
    tick(); tick();
  endtask

  initial begin
    do_reset();
    chk("rst_crst", crst, 1);
    chk("rst_cross", rc, 0);
    chk("rst_a", ra, 0);
    chk("rst_valid", rvalid, 0);
    chk("rst_overrun", ovr, 0);

    // Ten matched cycles plus the edge cycle
    start();
    chk("int_crst", crst, 0);
    for (int i = 0; i < 10; i++) begin drive(0, 1, 1); tick(); end
    drive(1, 1, 1); tick();
    chk("w1_cross", rc, 11);
    chk("w1_a", ra, SE ? 11 : 0);
    chk("w1_b", rb, SE ? 11 : 0);
    chk("w1_valid", rvalid, 1);
    chk("w1_crst", crst, 1);
    drive(0, 0, 0); tick();
    chk("w1_valid_pulse", rvalid, 0);
    chk("w1_hold", rc, 11);

    // A alternates, B steady; 8th cycle is the edge
    for (int i = 0; i < 7; i++) begin drive(0, (i % 2) == 0, 1); tick(); end
    drive(1, 0, 1); tick();
    chk("w2_cross", rc, 4);
    chk("w2_a", ra, SE ? 4 : 0);
    chk("w2_b", rb, SE ? 8 : 0);
    drive(0, 0, 0); tick();

    // Back-pressure: second window dropped
    result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(0, 1, 1); tick(); end
    drive(1, 1, 1); tick();
    chk("w3_cross", rc, 4);
    chk("w3_valid", rvalid, 1);
    chk("w3_overrun0", ovr, 0);
    drive(0, 0, 0); tick();
    for (int i = 0; i < 2; i++) begin drive(0, 1, 1); tick(); end
    drive(1, 1, 1); tick();
    chk("w4_kept", rc, 4);
    chk("w4_overrun", ovr, 1);
    chk("w4_valid", rvalid, 1);
    drive(0, 0, 0); result_ready = 1'b1; tick();
    chk("w4_consumed", rvalid, 0);
    chk("w4_overrun_sticky", ovr, 1);

    // Handshake coinciding with window end
    do_reset();
    chk("rst2_overrun", ovr, 0);
    start();
    result_ready = 1'b0;
    drive(0, 1, 1); tick();
    drive(1, 1, 1); tick();
    chk("w5_cross", rc, 2);
    drive(0, 0, 0); tick();
    for (int i = 0; i < 2; i++) begin drive(0, 1, 0); tick(); end
    drive(1, 1, 0); result_ready = 1'b1; tick();
    chk("w6_cross", rc, 0);
    chk("w6_a", ra, SE ? 3 : 0);
    chk("w6_valid", rvalid, 1);
    chk("w6_overrun", ovr, 0);

    // Enable drop mid-window, then re-arm
    drive(0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 1); tick(); end
    enable = 1'b0; tick();
    chk("idle_crst", crst, 1);
    chk("idle_res_kept", rc, 0);
    tick();
    enable = 1'b1; tick();
    drive(1, 1, 1); tick();
    chk("restart_crst", crst, 1);
    drive(0, 1, 1); tick();
    chk("reint_crst", crst, 0);
    for (int i = 0; i < 2; i++) begin drive(0, 1, 1); tick(); end
    drive(1, 0, 0); tick();
    chk("w7_cross", rc, 2);
    chk("w7_a", ra, SE ? 2 : 0);

    // Reset mid-window
    drive(0, 0, 0); tick();
    drive(0, 1, 1); tick();
    reset = 1'b0; tick();
    chk("mrst_cross", rc, 0);
    chk("mrst_a", ra, 0);
    chk("mrst_valid", rvalid, 0);
    chk("mrst_crst", crst, 1);
    reset = 1'b1;

    // Saturation at 4 bits
    do_reset();
    start();
    for (int i = 0; i < 19; i++) begin drive(0, 1, 1); tick(); end
    drive(1, 1, 1); tick();
    chk("sat_cross", rc4, 15);
    chk("sat_a", ra4, SE ? 15 : 0);
    chk("sat_b", rb4, SE ? 15 : 0);
    chk("sat_wide_cross", rc, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
